// File: rtl/tx_pkt_fifo.sv
// Store-and-forward AXIS frame FIFO ahead of the 10G TX path; a frame leaves only once fully stored (first beat 2 cycles after its tlast).
// s_tready_o never deasserts: aborted or overflowing frames are dropped whole and counted; m_* holds while m_tready_i=0.
module tx_pkt_fifo #(
  parameter int ADDR_W    = 9,
  parameter int PKT_CNT_W = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [31:0]          s_tdata_i,
  input  logic [1:0]           s_tvldb_i,
  input  logic                 s_tvalid_i,
  output logic                 s_tready_o,
  input  logic                 s_tlast_i,
  input  logic                 s_tuser_i,
  output logic [31:0]          m_tdata_o,
  output logic [1:0]           m_tvldb_o,
  output logic                 m_tvalid_o,
  input  logic                 m_tready_i,
  output logic                 m_tlast_o,
  output logic                 m_tuser_o,
  output logic [PKT_CNT_W-1:0] pkt_cnt_o,
  output logic                 drop_o,
  output logic [15:0]          drop_cnt_o
);

  localparam int                   DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0]    A_ONE = ADDR_W'(1);
  localparam logic [PKT_CNT_W-1:0] P_ONE = PKT_CNT_W'(1);

  typedef struct packed {
    logic        last;
    logic [1:0]  vldb;
    logic [31:0] data;
  } ent_t;

  typedef enum logic [1:0] {W_IDLE, W_WRITE, W_DROP} wst_t;

  ent_t                 mem [DEPTH];
  wst_t                 wst_q, wst_d;
  logic [ADDR_W-1:0]    wr_ptr_q, wr_tmp_q, rd_ptr_q;
  logic [PKT_CNT_W-1:0] pkt_cnt_q;
  logic                 rdy_q;
  logic                 drop_q;
  logic [15:0]          drop_cnt_q;
  logic                 beat, full, can_store, wr_en, commit, discard;
  ent_t                 wr_ent, out_q;
  logic                 out_vld_q, rd_hs, rd_done, load;

  assign beat = s_tvalid_i & rdy_q;
  // One slot always stays free so wr_tmp catching rd_ptr is unambiguous.
  assign full = (wr_tmp_q + A_ONE) == rd_ptr_q;

  always_comb begin
    wr_ent      = '0;
    wr_ent.last = s_tlast_i;
    wr_ent.vldb = s_tlast_i ? s_tvldb_i : 2'b11;
    wr_ent.data = s_tdata_i;
  end

  // Write FSM: state register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) wst_q <= W_IDLE;
    else          wst_q <= wst_d;
  end

  // Write FSM: next state
  always_comb begin
    wst_d = wst_q;
    if (beat) begin
      if (s_tlast_i)       wst_d = W_IDLE;
      else if (!can_store) wst_d = W_DROP;
      else                 wst_d = W_WRITE;
    end
  end

  // Write FSM: outputs
  always_comb begin
    can_store = 1'b0;
    case (wst_q)
      W_IDLE:  can_store = !full && (pkt_cnt_q != '1);
      W_WRITE: can_store = !full;
      default: can_store = 1'b0;
    endcase
    wr_en   = beat & can_store;
    commit  = wr_en & s_tlast_i & ~s_tuser_i;
    discard = beat & s_tlast_i & (~can_store | s_tuser_i);
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_tmp_q] <= wr_ent;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q   <= '0;
      wr_tmp_q   <= '0;
      rdy_q      <= 1'b0;
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      rdy_q  <= 1'b1;
      drop_q <= discard;
      if (discard)    wr_tmp_q <= wr_ptr_q;
      else if (wr_en) wr_tmp_q <= wr_tmp_q + A_ONE;
      if (commit) wr_ptr_q <= wr_tmp_q + A_ONE;
      if (discard && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  // A new frame may only be fetched when another committed frame is behind the one on the output.
  assign rd_hs   = out_vld_q & m_tready_i;
  assign rd_done = rd_hs & out_q.last;
  assign load    = out_vld_q ? (rd_hs & (~out_q.last | (pkt_cnt_q > P_ONE)))
                             : (pkt_cnt_q != '0);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_ptr_q  <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
      pkt_cnt_q <= '0;
    end else begin
      if (load) begin
        out_q     <= mem[rd_ptr_q];
        out_vld_q <= 1'b1;
        rd_ptr_q  <= rd_ptr_q + A_ONE;
      end else if (rd_hs) begin
        out_vld_q <= 1'b0;
      end
      case ({commit, rd_done})
        2'b10:   pkt_cnt_q <= pkt_cnt_q + P_ONE;
        2'b01:   pkt_cnt_q <= pkt_cnt_q - P_ONE;
        default: pkt_cnt_q <= pkt_cnt_q;
      endcase
    end
  end

  assign s_tready_o = rdy_q;
  assign m_tdata_o  = out_q.data;
  assign m_tvldb_o  = out_q.vldb;
  assign m_tlast_o  = out_q.last;
  assign m_tvalid_o = out_vld_q;
  assign m_tuser_o  = 1'b0;
  assign pkt_cnt_o  = pkt_cnt_q;
  assign drop_o     = drop_q;
  assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_tx_pkt_fifo.sv
// Scoreboard bench for tx_pkt_fifo: default-size instance plus a 16-entry instance for overflow.
module tb_tx_pkt_fifo;

  typedef logic [34:0] beat_t;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  logic rst_n_i;

  logic [31:0] s_tdata, m_tdata, s_tdata_b, m_tdata_b;
  logic [1:0]  s_tvldb, m_tvldb, s_tvldb_b, m_tvldb_b;
  logic        s_tvalid, s_tready, s_tlast, s_tuser;
  logic        m_tvalid, m_tready, m_tlast, m_tuser;
  logic        s_tvalid_b, s_tready_b, s_tlast_b, s_tuser_b;
  logic        m_tvalid_b, m_tready_b, m_tlast_b, m_tuser_b;
  logic [5:0]  pkt_cnt, pkt_cnt_b;
  logic        drop, drop_b;
  logic [15:0] drop_cnt, drop_cnt_b;

  tx_pkt_fifo dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .s_tdata_i(s_tdata), .s_tvldb_i(s_tvldb), .s_tvalid_i(s_tvalid), .s_tready_o(s_tready),
    .s_tlast_i(s_tlast), .s_tuser_i(s_tuser),
    .m_tdata_o(m_tdata), .m_tvldb_o(m_tvldb), .m_tvalid_o(m_tvalid), .m_tready_i(m_tready),
    .m_tlast_o(m_tlast), .m_tuser_o(m_tuser),
    .pkt_cnt_o(pkt_cnt), .drop_o(drop), .drop_cnt_o(drop_cnt)
  );

  tx_pkt_fifo #(.ADDR_W(4), .PKT_CNT_W(6)) dut_b (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .s_tdata_i(s_tdata_b), .s_tvldb_i(s_tvldb_b), .s_tvalid_i(s_tvalid_b), .s_tready_o(s_tready_b),
    .s_tlast_i(s_tlast_b), .s_tuser_i(s_tuser_b),
    .m_tdata_o(m_tdata_b), .m_tvldb_o(m_tvldb_b), .m_tvalid_o(m_tvalid_b), .m_tready_i(m_tready_b),
    .m_tlast_o(m_tlast_b), .m_tuser_o(m_tuser_b),
    .pkt_cnt_o(pkt_cnt_b), .drop_o(drop_b), .drop_cnt_o(drop_cnt_b)
  );

  int    vectors = 0;
  int    miscompares = 0;
  int    drop_hi = 0;
  int    drop_b_hi = 0;
  beat_t exp_q[$];
  beat_t exp_b_q[$];
  bit    t5_done;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic no_beat(input string name, input beat_t act);
    vectors++;
    miscompares++;
    $display("FAIL %s: got beat %0h, required no beat", name, act);
  endtask

  // Monitor for the default instance: order, contiguity within a frame, hold under backpressure.
  bit    in_frame = 1'b0;
  bit    hold_chk = 1'b0;
  beat_t prev;
  always @(negedge clk_i) begin
    if (!rst_n_i) begin
      in_frame = 1'b0;
      hold_chk = 1'b0;
    end else begin
      if (drop) drop_hi++;
      if (in_frame) chk("no_bubble", m_tvalid, 1);
      if (hold_chk) chk("hold_stable", {m_tvalid, m_tlast, m_tvldb, m_tdata}, {1'b1, prev});
      if (m_tvalid) chk("m_tuser", m_tuser, 0);
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) no_beat("unexpected_beat", {m_tlast, m_tvldb, m_tdata});
        else chk("beat", {m_tlast, m_tvldb, m_tdata}, exp_q.pop_front());
        in_frame = !m_tlast;
      end
      hold_chk = m_tvalid && !m_tready;
      prev     = {m_tlast, m_tvldb, m_tdata};
    end
  end

  always @(negedge clk_i) begin
    if (rst_n_i) begin
      if (drop_b) drop_b_hi++;
      if (m_tvalid_b && m_tready_b) begin
        chk("b_tuser", m_tuser_b, 0);
        if (exp_b_q.size() == 0) no_beat("b_unexpected_beat", {m_tlast_b, m_tvldb_b, m_tdata_b});
        else chk("b_beat", {m_tlast_b, m_tvldb_b, m_tdata_b}, exp_b_q.pop_front());
      end
    end
  end

  task automatic sync();
    @(posedge clk_i);
    #1;
  endtask

  // Non-last beats drive tvldb=0 to confirm it is ignored (stored as 3).
  task automatic send(input bit to_b, input int len, input logic [1:0] lvldb, input bit abort,
                      input logic [31:0] base, input bit keep);
    for (int i = 0; i < len; i++) begin
      logic [31:0] d;
      logic        lst;
      beat_t       e;
      d   = base + 32'(i);
      lst = (i == len - 1);
      e   = {lst, (lst ? lvldb : 2'b11), d};
      if (to_b) begin
        s_tdata_b = d; s_tvldb_b = lst ? lvldb : 2'b00; s_tlast_b = lst;
        s_tuser_b = lst & abort; s_tvalid_b = 1'b1;
        if (keep) exp_b_q.push_back(e);
      end else begin
        s_tdata = d; s_tvldb = lst ? lvldb : 2'b00; s_tlast = lst;
        s_tuser = lst & abort; s_tvalid = 1'b1;
        if (keep) exp_q.push_back(e);
      end
      sync();
    end
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    s_tvalid_b = 1'b0; s_tlast_b = 1'b0; s_tuser_b = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_b_q.size() != 0 || m_tvalid || m_tvalid_b) && n < 5000) begin
      @(negedge clk_i);
      n++;
    end
    chk({name, "_drained"}, 64'(exp_q.size() + exp_b_q.size()), 0);
    sync();
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    rst_n_i = 1'b0;
    s_tdata = '0; s_tvldb = '0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    s_tdata_b = '0; s_tvldb_b = '0; s_tvalid_b = 1'b0; s_tlast_b = 1'b0; s_tuser_b = 1'b0;
    m_tready = 1'b1; m_tready_b = 1'b1;
    repeat (3) sync();

    chk("rst_s_tready", s_tready, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tlast", m_tlast, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_m_tvldb", m_tvldb, 0);
    chk("rst_drop", drop, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    rst_n_i = 1'b1;
    sync();
    chk("s_tready_after_rst", s_tready, 1);
    chk("b_s_tready_after_rst", s_tready_b, 1);

    // 16-beat frame, last tvldb=2: valid two cycles after tlast
    send(0, 16, 2'd2, 0, 32'hA000_0000, 1);
    @(negedge clk_i); chk("lat_tlast_plus1", m_tvalid, 0);
    @(negedge clk_i); chk("lat_tlast_plus2", m_tvalid, 1);
    wait_drain("t1");
    chk("t1_pkt_cnt", pkt_cnt, 0);

    // Aborted frame is swallowed, then a good frame passes
    d0 = drop_hi;
    send(0, 5, 2'd1, 1, 32'hB000_0000, 0);
    repeat (3) @(negedge clk_i);
    chk("t2_drop_pulse_cycles", 64'(drop_hi - d0), 1);
    chk("t2_drop_cnt", drop_cnt, 1);
    chk("t2_pkt_cnt", pkt_cnt, 0);
    chk("t2_no_output", m_tvalid, 0);
    sync();
    send(0, 4, 2'd3, 0, 32'hB100_0000, 1);
    wait_drain("t2");

    // 16-entry FIFO: 20-beat frame overflows and is dropped, 8-beat frame follows intact
    send(1, 20, 2'd0, 0, 32'hC000_0000, 0);
    repeat (3) @(negedge clk_i);
    chk("t3_drop_cnt", drop_cnt_b, 1);
    chk("t3_drop_pulse_cycles", 64'(drop_b_hi), 1);
    chk("t3_pkt_cnt", pkt_cnt_b, 0);
    sync();
    send(1, 8, 2'd1, 0, 32'hC100_0000, 1);
    wait_drain("t3");

    // Three single-beat frames held back, then released back-to-back
    m_tready = 1'b0;
    send(0, 1, 2'd0, 0, 32'hD000_0000, 1);
    send(0, 1, 2'd1, 0, 32'hD100_0000, 1);
    send(0, 1, 2'd2, 0, 32'hD200_0000, 1);
    repeat (2) @(negedge clk_i);
    chk("t4_pkt_cnt_3", pkt_cnt, 3);
    sync();
    m_tready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      chk("t4_valid_run", m_tvalid, 1);
      chk("t4_tlast_run", m_tlast, 1);
    end
    @(negedge clk_i);
    chk("t4_valid_after", m_tvalid, 0);
    chk("t4_pkt_cnt_0", pkt_cnt, 0);
    sync();

    // 200 frames with random backpressure; about 900 beats so pointers wrap
    t5_done = 1'b0;
    fork
      begin
        while (!t5_done) begin
          sync();
          m_tready = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        for (int f = 0; f < 200; f++) begin
          int len;
          len = $urandom_range(1, 8);
          send(0, len, 2'($urandom_range(0, 3)), 0, {8'hE0, 8'(f), 16'h0}, 1);
          repeat (len + 2) sync();
        end
        t5_done = 1'b1;
      end
    join
    m_tready = 1'b1;
    wait_drain("t5");
    chk("t5_drop_cnt", drop_cnt, 1);
    chk("t5_pkt_cnt", pkt_cnt, 0);

    // Reset in the middle of reading a frame
    send(0, 16, 2'd3, 0, 32'hF000_0000, 1);
    repeat (4) @(negedge clk_i);
    sync();
    rst_n_i = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_rst_m_tvalid", m_tvalid, 0);
    chk("t6_rst_pkt_cnt", pkt_cnt, 0);
    chk("t6_rst_drop_cnt", drop_cnt, 0);
    repeat (2) sync();
    rst_n_i = 1'b1;
    sync();
    send(0, 6, 2'd0, 0, 32'hF100_0000, 1);
    wait_drain("t6");
    chk("t6_pkt_cnt", pkt_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
